// File: rtl/axil_order_pkg.sv
// axil_order_pkg: shared op/state encodings, response constant and order layout
// for the AXI4-Lite order sequencer.
package axil_order_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int ORD_ADDR_W = 8;
    localparam int ORD_DATA_W = 32;
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_GAP
    } state_e;
    // Order at default bus widths; the top rebuilds the same layout at its own widths.
    typedef struct packed {
        op_e                   op;
        logic [ORD_ADDR_W-1:0] addr;
        logic [ORD_DATA_W-1:0] data;
    } order_t;
endpackage

// File: rtl/axil_order_master_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q, do_push, do_pop;
    // Push is gated by the registered full flag alone, so a same-cycle pop never frees a slot early.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_q + AW'(do_push);
            rptr_q  <= rptr_q + AW'(do_pop);
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
    assign data_o  = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/axil_order_master.sv
// axil_order_master: executes buffered (op, addr, data) orders in sequence on an
// AXI4-Lite master port: writes, reads with a response pulse, and poll-until-set waits.
module axil_order_master
    import axil_order_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int POLL_GAP        = 4,
    parameter int POLL_MAX        = 1024
) (
    input  logic                         m00_axi_aclk,
    input  logic                         m00_axi_areset,
    input  logic                         ord_valid,
    output logic                         ord_ready,
    input  logic [1:0]                   ord_op,
    input  logic [AXIL_ADDR_WIDTH-1:0]   ord_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   ord_data,
    output logic                         rsp_valid,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_data,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                   m00_axi_awprot,
    output logic                         m00_axi_awvalid,
    input  logic                         m00_axi_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                         m00_axi_wvalid,
    input  logic                         m00_axi_wready,
    input  logic [1:0]                   m00_axi_bresp,
    input  logic                         m00_axi_bvalid,
    output logic                         m00_axi_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                   m00_axi_arprot,
    output logic                         m00_axi_arvalid,
    input  logic                         m00_axi_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                   m00_axi_rresp,
    input  logic                         m00_axi_rvalid,
    output logic                         m00_axi_rready,
    output logic                         busy,
    output logic                         err,
    output logic                         timeout,
    output logic [31:0]                  ord_count
);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = POLL_GAP > 0 ? $clog2(POLL_GAP + 1) : 1;
    typedef struct packed {
        op_e                        op;
        logic [AXIL_ADDR_WIDTH-1:0] addr;
        logic [AXIL_DATA_WIDTH-1:0] data;
    } ord_t;
    localparam int OW = $bits(ord_t);

    state_e                     state_q, state_d;
    ord_t                       cur_q, cur_d, head;
    logic                       awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [PW-1:0]              poll_cnt_q, poll_cnt_d;
    logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
    logic                       rsp_valid_q, rsp_valid_d, err_q, err_d, timeout_q, timeout_d;
    logic [AXIL_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [31:0]                ord_count_q, ord_count_d;
    logic                       fifo_full, fifo_empty, pop, retire, poll_hit;
    logic [OW-1:0]              fifo_dout;

    sync_fifo #(.WIDTH(OW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (m00_axi_aclk),
        .rst_i  (m00_axi_areset),
        .push_i (ord_valid),
        .data_i ({ord_op, ord_addr, ord_data}),
        .pop_i  (pop),
        .data_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );
    assign head = ord_t'(fifo_dout);
    // An error response never satisfies a poll, whatever the data bits say.
    assign poll_hit = m00_axi_rresp == RESP_OKAY && |(m00_axi_rdata & cur_q.data);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        ord_count_d = ord_count_q;
        pop         = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                pop   = 1'b1;
                cur_d = head;
                if (head.op == OP_WRITE) begin
                    state_d   = S_WADDR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (head.op == OP_NOP) begin
                    retire = 1'b1;
                end else begin
                    state_d   = S_RADDR;
                    arvalid_d = 1'b1;
                end
            end
            S_WADDR: begin
                awvalid_d = awvalid_q && !m00_axi_awready;
                wvalid_d  = wvalid_q && !m00_axi_wready;
                state_d   = (!awvalid_d && !wvalid_d) ? S_WRESP : S_WADDR;
            end
            S_WRESP: if (m00_axi_bvalid) begin
                err_d  = err_q || m00_axi_bresp != RESP_OKAY;
                retire = 1'b1;
            end
            S_RADDR: if (m00_axi_arready) begin
                arvalid_d = 1'b0;
                state_d   = S_RDATA;
            end
            S_RDATA: if (m00_axi_rvalid) begin
                err_d = err_q || m00_axi_rresp != RESP_OKAY;
                if (cur_q.op == OP_READ) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = m00_axi_rdata;
                    retire      = 1'b1;
                end else if (poll_hit) begin
                    retire = 1'b1;
                end else if (int'(poll_cnt_q) + 1 == POLL_MAX) begin
                    timeout_d = 1'b1;
                    retire    = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                    gap_cnt_d  = '0;
                    state_d    = POLL_GAP == 0 ? S_RADDR : S_GAP;
                    arvalid_d  = POLL_GAP == 0;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (int'(gap_cnt_q) + 1 == POLL_GAP) begin
                    state_d   = S_RADDR;
                    arvalid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            state_d     = S_IDLE;
            ord_count_d = ord_count_q + 32'd1;
            poll_cnt_d  = '0;
        end
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            ord_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            ord_count_q <= ord_count_d;
        end
    end

    assign ord_ready       = !fifo_full;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign m00_axi_awaddr  = cur_q.addr;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = cur_q.data;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = state_q == S_WRESP;
    assign m00_axi_araddr  = cur_q.addr;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = state_q == S_RDATA;
    assign busy            = !fifo_empty || state_q != S_IDLE;
    assign err             = err_q;
    assign timeout         = timeout_q;
    assign ord_count       = ord_count_q;
endmodule

// File: tb/tb_axil_order_master.sv
// tb_axil_order_master: directed scenarios against a small AXI4-Lite slave model
// with per-transaction logs; DUT built with POLL_MAX=4.
module tb_axil_order_master;
    localparam logic [1:0] WR = 2'b00, RD = 2'b01, PL = 2'b10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ord_valid = 1'b0, ord_ready;
    logic [1:0]  ord_op = 2'b00;
    logic [7:0]  ord_addr = 8'h0;
    logic [31:0] ord_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic        busy, err, timeout;
    logic [31:0] ord_count;
    int total = 0;
    int bad = 0;

    logic        aw_rdy_en = 1'b1;
    logic [1:0]  bresp_tab [64];
    logic [31:0] rd_tab [64];
    logic [7:0]  aw_log [64];
    logic [31:0] w_log [64];
    logic [7:0]  ar_log [64];
    int          aw_cyc [64];
    int          ar_cyc [64];
    int          aw_n, w_n, b_n, ar_n;
    int          cyc = 0;
    logic        aw_pend, w_pend;

    axil_order_master #(.POLL_MAX(4)) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(rst),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_op(ord_op),
        .ord_addr(ord_addr), .ord_data(ord_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready),
        .busy(busy), .err(err), .timeout(timeout), .ord_count(ord_count)
    );

    assign awready = aw_rdy_en;
    assign wready  = 1'b1;
    assign arready = 1'b1;

    // Slave answers B one cycle after both AW and W have handshaken, R one cycle after AR.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0;
            aw_pend <= 1'b0; w_pend <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) begin
                aw_log[aw_n] <= awaddr;
                aw_cyc[aw_n] <= cyc;
                aw_n <= aw_n + 1;
            end
            if (wvalid && wready) begin
                w_log[w_n] <= wdata;
                w_n <= w_n + 1;
            end
            if ((aw_pend || (awvalid && awready)) && (w_pend || (wvalid && wready))) begin
                bvalid <= 1'b1;
                bresp <= bresp_tab[b_n];
                b_n <= b_n + 1;
                aw_pend <= 1'b0;
                w_pend <= 1'b0;
            end else begin
                if (awvalid && awready) aw_pend <= 1'b1;
                if (wvalid && wready) w_pend <= 1'b1;
            end
            if (arvalid && arready) begin
                ar_log[ar_n] <= araddr;
                ar_cyc[ar_n] <= cyc;
                rvalid <= 1'b1;
                rdata <= rd_tab[ar_n];
                rresp <= 2'b00;
                ar_n <= ar_n + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ord_valid = 1'b0;
        aw_rdy_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bresp_tab[i] = 2'b00;
            rd_tab[i] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d, output bit acc);
        @(negedge clk);
        ord_valid = 1'b1; ord_op = op; ord_addr = a; ord_data = d;
        acc = ord_ready;
        @(negedge clk);
        ord_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle busy=%0b after %0d cycles, want 0", tag, busy, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin bad++; $display("FAIL reset_axi got=%b want=00000", {awvalid, wvalid, arvalid, bready, rready}); end
        total++;
        if ({rsp_valid, err, timeout, busy} !== 4'b0 || rsp_data !== 32'h0) begin bad++; $display("FAIL reset_flags got=%b rsp_data=%h want=0000/0", {rsp_valid, err, timeout, busy}, rsp_data); end
        total++;
        if (ord_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ord_count); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ord_ready !== 1'b1) begin bad++; $display("FAIL reset_ord_ready got=%b want=1", ord_ready); end
    endtask

    task automatic test_write();
        bit acc;
        do_reset();
        push(WR, 8'h48, 32'h1, acc);
        total++;
        if (busy !== 1'b1 || awvalid !== 1'b0) begin bad++; $display("FAIL write_pop busy=%b awvalid=%b want 1/0", busy, awvalid); end
        @(negedge clk);
        total++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== 8'h48 || wdata !== 32'h1) begin bad++; $display("FAIL write_aw valid=%b addr=%h data=%h want 11/48/00000001", {awvalid, wvalid}, awaddr, wdata); end
        total++;
        if (wstrb !== 4'hf || awprot !== 3'b0 || arprot !== 3'b0) begin bad++; $display("FAIL write_strb wstrb=%h prot=%b/%b want f/000/000", wstrb, awprot, arprot); end
        @(negedge clk);
        total++;
        if (bready !== 1'b1 || {awvalid, wvalid} !== 2'b00) begin bad++; $display("FAIL write_b bready=%b valid=%b want 1/00", bready, {awvalid, wvalid}); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ord_count !== 32'd1) begin bad++; $display("FAIL write_done busy=%b count=%0d want 0/1", busy, ord_count); end
        total++;
        if (aw_n !== 1 || aw_log[0] !== 8'h48 || w_log[0] !== 32'h1) begin bad++; $display("FAIL write_log n=%0d addr=%h data=%h want 1/48/00000001", aw_n, aw_log[0], w_log[0]); end
    endtask

    task automatic test_poll();
        bit acc;
        do_reset();
        rd_tab[2] = 32'h1;
        push(PL, 8'h4c, 32'h1, acc);
        push(WR, 8'h48, 32'h5, acc);
        wait_idle("poll");
        total++;
        if (ar_n !== 3 || ar_log[0] !== 8'h4c) begin bad++; $display("FAIL poll_reads n=%0d addr=%h want 3/4c", ar_n, ar_log[0]); end
        total++;
        if (ar_cyc[1] - ar_cyc[0] !== 6 || ar_cyc[2] - ar_cyc[1] !== 6) begin bad++; $display("FAIL poll_gap got=%0d,%0d want 6,6", ar_cyc[1] - ar_cyc[0], ar_cyc[2] - ar_cyc[1]); end
        total++;
        if (aw_n !== 1 || aw_log[0] !== 8'h48 || aw_cyc[0] - ar_cyc[2] !== 3) begin bad++; $display("FAIL poll_next n=%0d addr=%h delay=%0d want 1/48/3", aw_n, aw_log[0], aw_cyc[0] - ar_cyc[2]); end
        total++;
        if (ord_count !== 32'd2 || timeout !== 1'b0) begin bad++; $display("FAIL poll_count count=%0d timeout=%b want 2/0", ord_count, timeout); end
    endtask

    task automatic test_timeout();
        bit acc;
        do_reset();
        push(PL, 8'h4c, 32'h1, acc);
        push(WR, 8'h48, 32'h7, acc);
        wait_idle("timeout");
        total++;
        if (ar_n !== 4) begin bad++; $display("FAIL timeout_reads got=%0d want 4", ar_n); end
        total++;
        if (timeout !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL timeout_flag timeout=%b err=%b want 1/0", timeout, err); end
        total++;
        if (ord_count !== 32'd2 || aw_n !== 1 || w_log[0] !== 32'h7) begin bad++; $display("FAIL timeout_next count=%0d writes=%0d data=%h want 2/1/00000007", ord_count, aw_n, w_log[0]); end
    endtask

    task automatic test_read();
        bit acc;
        int pulses = 0;
        logic [31:0] got = '0;
        do_reset();
        rd_tab[0] = 32'hdeadbeef;
        push(RD, 8'h10, 32'h0, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                got = rsp_data;
            end
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL read_pulses got=%0d want 1", pulses); end
        total++;
        if (got !== 32'hdeadbeef) begin bad++; $display("FAIL read_data got=%h want deadbeef", got); end
        total++;
        if (ar_n !== 1 || ar_log[0] !== 8'h10 || ord_count !== 32'd1) begin bad++; $display("FAIL read_ar n=%0d addr=%h count=%0d want 1/10/1", ar_n, ar_log[0], ord_count); end
    endtask

    task automatic test_full();
        bit acc;
        int accepted = 0;
        int tries = 0;
        int wrong = 0;
        do_reset();
        aw_rdy_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push(WR, 8'(4 * i), 32'h100 + 32'(i), acc);
            if (acc) accepted++;
        end
        total++;
        if (accepted !== 17 || ord_ready !== 1'b0) begin bad++; $display("FAIL full_accept got=%0d ord_ready=%b want 17/0", accepted, ord_ready); end
        aw_rdy_en = 1'b1;
        acc = 1'b0;
        while (!acc && tries < 40) begin
            push(WR, 8'(4 * 17), 32'h100 + 32'd17, acc);
            tries++;
        end
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL full_retry accepted=%b after %0d tries want 1", acc, tries); end
        wait_idle("full");
        for (int i = 0; i < 18; i++)
            if (aw_log[i] !== 8'(4 * i) || w_log[i] !== 32'h100 + 32'(i)) wrong++;
        total++;
        if (aw_n !== 18 || wrong !== 0) begin bad++; $display("FAIL full_order writes=%0d misordered=%0d want 18/0", aw_n, wrong); end
        total++;
        if (aw_cyc[2] - aw_cyc[1] !== 3) begin bad++; $display("FAIL full_b2b spacing=%0d want 3", aw_cyc[2] - aw_cyc[1]); end
        total++;
        if (ord_count !== 32'd18) begin bad++; $display("FAIL full_count got=%0d want 18", ord_count); end
    endtask

    task automatic test_bresp_err();
        bit acc;
        do_reset();
        bresp_tab[1] = 2'b10;
        for (int i = 0; i < 3; i++) push(WR, 8'h30 + 8'(i), 32'(i), acc);
        wait_idle("bresp");
        total++;
        if (err !== 1'b1 || ord_count !== 32'd3 || aw_n !== 3) begin bad++; $display("FAIL bresp_err err=%b count=%0d writes=%0d want 1/3/3", err, ord_count, aw_n); end
        push(WR, 8'h40, 32'h9, acc);
        wait_idle("bresp_sticky");
        total++;
        if (err !== 1'b1 || ord_count !== 32'd4) begin bad++; $display("FAIL bresp_sticky err=%b count=%0d want 1/4", err, ord_count); end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int n = 0;
        aw_rdy_en = 1'b0;
        push(WR, 8'h20, 32'h55, acc);
        while (!awvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (awvalid !== 1'b1) begin bad++; $display("FAIL mid_waddr awvalid=%b want 1", awvalid); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({awvalid, wvalid, bready, busy} !== 4'b0 || ord_count !== 32'd0) begin bad++; $display("FAIL mid_reset valid/busy=%b count=%0d want 0000/0", {awvalid, wvalid, bready, busy}, ord_count); end
        total++;
        if (err !== 1'b0 || timeout !== 1'b0 || ord_ready !== 1'b1) begin bad++; $display("FAIL mid_flags err=%b timeout=%b ord_ready=%b want 0/0/1", err, timeout, ord_ready); end
        rst = 1'b0;
        aw_rdy_en = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (aw_n !== 0 || busy !== 1'b0) begin bad++; $display("FAIL mid_flush writes=%0d busy=%b want 0/0", aw_n, busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_poll();
        test_timeout();
        test_read();
        test_full();
        test_bresp_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
